// File: rtl/if_stage_pkg.sv
// Shared fetch-side definitions for the MIPS32 core.
// Word constants, chip-enable levels and fetch state encoding.
package if_stage_pkg;

    localparam int          inst_addr_w  = 32;
    localparam int          inst_w       = 32;
    localparam logic [31:0] zero_word    = 32'h0000_0000;
    localparam logic [31:0] nop_inst     = zero_word;
    localparam logic        chip_enable  = 1'b1;
    localparam logic        chip_disable = 1'b0;

    typedef enum logic {
        FETCH_DISABLED = 1'b0,
        FETCH_RUN      = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/if_stage_pc_reg.sv
// Program counter and fetch enable for the instruction ROM.
// Redirect targets are forced word aligned.
module pc_reg
    import if_stage_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_if,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr
);

    localparam logic [ADDR_W-1:0] align_mask =
        {{(ADDR_W-2){1'b1}}, 2'b00};

    fetch_state_e      state;
    logic [ADDR_W-1:0] pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= FETCH_DISABLED;
            rom_ce <= chip_disable;
            pc     <= RESET_PC;
        end else begin
            unique case (state)
                FETCH_DISABLED: begin
                    state  <= FETCH_RUN;
                    rom_ce <= chip_enable;
                end
                FETCH_RUN: begin
                    if (flush)
                        pc <= flush_pc & align_mask;
                    else if (stall_if)
                        pc <= pc;
                    else if (branch_flag)
                        pc <= branch_target & align_mask;
                    else
                        pc <= pc + ADDR_W'(4);
                end
                default: state <= FETCH_DISABLED;
            endcase
        end
    end

    assign rom_addr = pc;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, ROM access and IF/ID register.
// Macro BRANCH_DELAY_SLOT_EN keeps the delay-slot fetch on a branch.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_if,
    input  logic              stall_id,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [INST_W-1:0] rom_inst,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0] id_inst,
    output logic              id_valid
);

    pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk           (clk),
        .rst           (rst),
        .stall_if      (stall_if),
        .flush         (flush),
        .flush_pc      (flush_pc),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .rom_ce        (rom_ce),
        .rom_addr      (rom_addr)
    );

    logic bubble;
    logic hold;

    // stall_id alone only reaches here together with stall_if
    always_comb begin
        bubble = 1'b0;
        hold   = 1'b0;
        if (flush)
            bubble = 1'b1;
        else if (stall_if && !stall_id)
            bubble = 1'b1;
        else if (stall_id)
            hold = 1'b1;
        else if (rom_ce == chip_disable)
            bubble = 1'b1;
`ifndef BRANCH_DELAY_SLOT_EN
        else if (branch_flag)
            bubble = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_pc    <= ADDR_W'(zero_word);
            id_inst  <= INST_W'(nop_inst);
            id_valid <= 1'b0;
        end else if (bubble) begin
            id_pc    <= ADDR_W'(zero_word);
            id_inst  <= INST_W'(nop_inst);
            id_valid <= 1'b0;
        end else if (!hold) begin
            id_pc    <= rom_addr;
            id_inst  <= rom_inst;
            id_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage against a fetch-rule model.
// Honours BRANCH_DELAY_SLOT_EN in its expectations.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_if = 1'b0;
    logic        stall_id = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = '0;
    logic        branch_flag = 1'b0;
    logic [31:0] branch_target = '0;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, ~a[15:0]};
    endfunction

    assign rom_inst = rom_word(rom_addr);

    if_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall_if      (stall_if),
        .stall_id      (stall_id),
        .flush         (flush),
        .flush_pc      (flush_pc),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .rom_ce        (rom_ce),
        .rom_addr      (rom_addr),
        .rom_inst      (rom_inst),
        .id_pc         (id_pc),
        .id_inst       (id_inst),
        .id_valid      (id_valid)
    );

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Fetch model: running flag, current PC, and the ID slot contents
    logic        m_run;
    logic [31:0] m_pc;
    logic [31:0] m_id_pc;
    logic [31:0] m_id_inst;
    logic        m_id_valid;
    bit          delay_slot;

    initial begin
`ifdef BRANCH_DELAY_SLOT_EN
        delay_slot = 1'b1;
`else
        delay_slot = 1'b0;
`endif
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_run = 0; m_pc = 0;
            m_id_pc = 0; m_id_inst = 0; m_id_valid = 0;
        end else begin
            bit take;
            bit keep;
            keep = stall_if && stall_id && !flush;
            take = !flush && !stall_if && m_run
                   && !(branch_flag && !delay_slot);
            if (!keep) begin
                m_id_valid = take;
                m_id_pc    = take ? m_pc : 0;
                m_id_inst  = take ? rom_word(m_pc) : 0;
            end
            if (!m_run)
                m_run = 1;
            else if (flush)
                m_pc = {flush_pc[31:2], 2'b00};
            else if (!stall_if)
                m_pc = branch_flag ? {branch_target[31:2], 2'b00}
                                   : m_pc + 4;
        end
    end

    always @(negedge clk) begin
        chk("rom_ce", 32'(rom_ce), 32'(m_run));
        chk("rom_addr", rom_addr, m_pc);
        chk("id_valid", 32'(id_valid), 32'(m_id_valid));
        chk("id_pc", id_pc, m_id_pc);
        chk("id_inst", id_inst, m_id_inst);
    end

    task automatic step(input logic si, input logic sd,
                        input logic fl, input logic [31:0] fp,
                        input logic br, input logic [31:0] bt);
        stall_if = si; stall_id = sd;
        flush = fl; flush_pc = fp;
        branch_flag = br; branch_target = bt;
        @(posedge clk);
        #2;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic lit_id(input string name, input logic v,
                          input logic [31:0] pc,
                          input logic [31:0] inst);
        chk({name, "_valid"}, 32'(id_valid), 32'(v));
        chk({name, "_pc"}, id_pc, pc);
        chk({name, "_inst"}, id_inst, inst);
    endtask

    initial begin
        #2;
        chk("rst_ce", 32'(rom_ce), 0);
        chk("rst_addr", rom_addr, 0);
        lit_id("rst_id", 0, 0, 0);
        #10 rst = 1'b1;
        step(0, 0, 0, 0, 0, 0);
        chk("e1_ce", 32'(rom_ce), 1);
        chk("e1_addr", rom_addr, 0);
        chk("e1_valid", 32'(id_valid), 0);
        step(0, 0, 0, 0, 0, 0);
        chk("e2_addr", rom_addr, 32'h4);
        lit_id("e2_id", 1, 0, rom_word(0));
        step(0, 0, 0, 0, 0, 0);
        chk("e3_addr", rom_addr, 32'h8);
        run(2);
        chk("pre_stall", rom_addr, 32'h10);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 0, 0, 0);
            chk("stall_addr", rom_addr, 32'h10);
            lit_id("stall_id", 1, 32'hC, rom_word(32'hC));
        end
        step(0, 0, 0, 0, 0, 0);
        chk("resume_addr", rom_addr, 32'h14);
        step(1, 0, 0, 0, 0, 0);
        chk("sif_addr", rom_addr, 32'h14);
        lit_id("sif_bub", 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        lit_id("sif_next", 1, 32'h14, rom_word(32'h14));
        run(3);
        lit_id("br_at_id", 1, 32'h20, rom_word(32'h20));
        step(0, 0, 0, 0, 1, 32'h100);
        chk("br_addr", rom_addr, 32'h100);
        if (delay_slot)
            lit_id("br_slot", 1, 32'h24, rom_word(32'h24));
        else
            lit_id("br_slot", 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        lit_id("br_tgt", 1, 32'h100, rom_word(32'h100));
        step(0, 0, 1, 32'h180, 1, 32'h200);
        chk("fl_addr", rom_addr, 32'h180);
        lit_id("fl_bub", 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        lit_id("fl_next", 1, 32'h180, rom_word(32'h180));
        step(0, 0, 0, 0, 1, 32'h203);
        chk("br_align", rom_addr, 32'h200);
        step(1, 1, 1, 32'h32F, 0, 0);
        chk("fl_stall", rom_addr, 32'h32C);
        lit_id("fl_stall_id", 0, 0, 0);
        step(0, 0, 1, 32'hFFFF_FFFF, 0, 0);
        chk("wrap_pre", rom_addr, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 0, 0);
        chk("wrap_addr", rom_addr, 32'h0);
        lit_id("wrap_id", 1, 32'hFFFF_FFFC, rom_word(32'hFFFF_FFFC));
        for (int i = 0; i < 60; i++) begin
            logic si;
            si = ($urandom_range(0, 3) == 0);
            step(si, si & 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) == 0), $urandom,
                 ($urandom_range(0, 4) == 0), $urandom);
        end
        step(0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        #1;
        chk("mid_ce", 32'(rom_ce), 0);
        chk("mid_addr", rom_addr, 0);
        lit_id("mid_id", 0, 0, 0);
        @(negedge clk);
        #1 rst = 1'b1;
        step(0, 0, 0, 0, 0, 0);
        chk("mid_e1_ce", 32'(rom_ce), 1);
        chk("mid_e1_addr", rom_addr, 0);
        run(2);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the MIPS32 core: initiator side of the instruction-ROM interface. It owns the program counter, drives the ROM chip-enable and word address, and captures the combinationally returned instruction into the IF/ID pipeline register. It handles stall, branch redirect and pipeline flush.

## Interface
Parameters:
- `ADDR_W`, default 32: PC / instruction address width.
- `INST_W`, default 32: instruction width.
- `RESET_PC`, default 32'h0000_0000: first fetch address; bits [1:0] must be 0.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `stall_if`  in  1  hold the PC.
- `stall_id`  in  1  hold IF/ID. `stall_id=1` with `stall_if=0` is illegal.
- `flush`  in  1  exception/eret redirect.
- `flush_pc`  in  ADDR_W  redirect target for `flush`.
- `branch_flag`  in  1  taken branch/jump resolved in ID.
- `branch_target`  in  ADDR_W  branch destination.
- `rom_ce`  out  1  ROM chip enable; 1 = ChipEnable.
- `rom_addr`  out  ADDR_W  byte address of the fetch (equals PC).
- `rom_inst`  in  INST_W  instruction from ROM, valid in the same cycle.
- `id_pc`  out  ADDR_W  PC of the instruction in IF/ID.
- `id_inst`  out  INST_W  instruction in IF/ID. Bubble = ZeroWord (sll $0 = NOP).
- `id_valid`  out  1  IF/ID holds a real instruction.

## Operation
- Two fetch states:
  - DISABLED: `rom_ce=0`, PC held at `RESET_PC`. Entered on reset.
  - RUN: `rom_ce=1`. Entered at the first rising edge after `rst` deasserts, and stays there.
- PC update, per edge in RUN, in priority order:
  - `flush` → `flush_pc`
  - `stall_if` → hold
  - `branch_flag` → `branch_target`
  - otherwise → PC+4
- Target low bits: bits [1:0] of `flush_pc` and `branch_target` are forced to 00.
- Wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag.
- IF/ID update, per edge, in priority order:
  - `flush` → bubble (`id_valid=0`, `id_inst=0`, `id_pc=0`)
  - `stall_if && !stall_id` → bubble
  - `stall_id` → hold
  - `rom_ce=0` → bubble
  - otherwise → capture `rom_inst`, PC, and `id_valid=1`
- Branch slot handling depends on `BRANCH_DELAY_SLOT_EN` (see Configuration).
- Flush beats branch: when both are asserted, the PC takes `flush_pc` and IF/ID takes a bubble.

## Timing
- Reset values (asynchronous): `rom_ce=0`, PC (`rom_addr`) = `RESET_PC`, `id_pc=0`, `id_inst=0`, `id_valid=0`.
- Edge 1 after release: `rom_ce` becomes 1. PC stays `RESET_PC`, and IF/ID captures a bubble.
- Edge 2 after release: IF/ID captures the instruction at `RESET_PC`, and PC becomes `RESET_PC+4`.
- Latency: `rom_addr` change to `id_inst` valid is 1 edge. ROM-to-ID throughput is 1 instruction per cycle.
- Branch redirect: `branch_flag` is sampled only when `stall_if=0`. While stalled, ID holds `branch_flag` asserted. The redirected fetch appears on `rom_addr` the cycle after the sampling edge.
- Reset asserted mid-operation forces all outputs to their reset values immediately, with no clock required.

## Configuration
- Macro: `BRANCH_DELAY_SLOT_EN`.
- Defined (MIPS32 semantics): on a branch edge, the instruction currently fetched (the delay slot, PC = branch+4) is captured normally with `id_valid=1`.
- Undefined: on a branch edge, the current fetch is squashed and IF/ID takes a bubble. The only instruction that reaches ID after the branch is the one at `branch_target`.

## Structure
- Shared define file (`define.v`): `ZeroWord`, `ChipEnable`/`ChipDisable`, `InstAddrBus`, `InstBus`, `NopInst`. Reuse existing entries and add missing ones.
- Sub-module `pc_reg`: holds the PC and the DISABLED/RUN state, and drives `rom_ce`/`rom_addr`.
- `if_stage` instantiates `pc_reg` and contains the IF/ID register with its bubble logic.

## Test plan
- Reset release with `RESET_PC=0`:
  - `rom_ce` goes 0 → 1 at edge 1.
  - `rom_addr` sequence is 0, 0, 4, 8.
  - `id_valid` first rises at edge 2, with `id_pc=0`.
- `stall_if=stall_id=1` for 3 cycles at PC=0x10: `rom_addr` stays 0x10, IF/ID holds, and the sequence resumes with 0x14 after release.
- `stall_if=1, stall_id=0` for 1 cycle: exactly one bubble (`id_valid=0`, `id_inst=0`) enters ID, and PC is held.
- Branch at ID (PC 0x20, target 0x100):
  - With the macro: ID sees 0x24 then 0x100.
  - Without the macro: ID sees a bubble then 0x100.
- `flush=1` (`flush_pc=0x180`) together with `branch_flag=1`: next `rom_addr`=0x180, IF/ID takes a bubble, and the branch target is ignored.
- Wrap: PC 0xFFFF_FFFC then 0x0000_0000. Mid-run `rst` low: outputs return to reset values asynchronously.
